// File: rtl/lsu_pipe_ctrl_if.sv
// lsu_pipe_ctrl_if
//   Data-memory bus between the MEM-stage sequencer and the LSU.
//   valid/ready handshake: a request completes on a rising edge where
//   bus_valid & bus_ready are both high.
// Signals:
//   bus_valid  request valid (master -> slave)
//   bus_we     request is a write
//   bus_addr   request address, AW bits
//   bus_wdata  write data, DW bits
//   bus_mask   byte enables, DW/8 bits
//   bus_ready  slave accepts and completes the request this cycle
//   bus_rdata  read data, valid when bus_valid & bus_ready & !bus_we
// Modports: master (lsu_pipe_ctrl side), slave (memory/LSU side).
interface lsu_pipe_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            bus_valid;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW/8-1:0] bus_mask;
    logic            bus_ready;
    logic [DW-1:0]   bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_mask,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_mask,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/lsu_pipe_ctrl.sv
// lsu_pipe_ctrl
//   Sequences each MEM-stage load/store onto the data-memory bus and drives
//   the common pipe_en for all pipeline stage registers (WB included).
//   The pipeline is frozen while a request is outstanding; pipe_en pulses
//   for one cycle (DONE) once the bus completes, and a load's read data is
//   captured into load_data for the mem2reg path.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   mem_req/we/addr/wdata/mask  MEM-stage memory operation
//   bus             lsu_pipe_ctrl_if.master data-memory bus
//   pipe_en         pipeline register enable (0 while rst=0)
//   load_data       last completed load's data
//   busy            FSM not in IDLE
//   timeout_err     sticky abort flag (0 unless LSU_TIMEOUT_EN)
// Optional feature:
//   LSU_TIMEOUT_EN  abort a request after TIMEOUT_CYC REQ cycles without
//                   bus_ready; load_data <= 0 and timeout_err is set.
module lsu_pipe_ctrl #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_wdata,
    input  logic [DW/8-1:0]  mem_mask,
    lsu_pipe_ctrl_if.master  bus,
    output logic             pipe_en,
    output logic [DW-1:0]    load_data,
    output logic             busy,
    output logic             timeout_err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("lsu_pipe_ctrl: TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              valid_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   mask_q;
    logic [DW-1:0]     load_q;
    logic              abort;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic          terr_q;

    // Abort on the not-ready REQ cycle that would bring the count to
    // TIMEOUT_CYC; a ready in that cycle completes normally instead.
    assign abort = (state_q == REQ) && !bus.bus_ready && (cnt_q == LIMIT_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            if (state_q == IDLE && mem_req) begin
                cnt_q <= '0;
            end else if (state_q == REQ && !bus.bus_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (abort) begin
                terr_q <= 1'b1;
            end
        end
    end

    assign timeout_err = terr_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pipe_en = 1'b0;
        case (state_q)
            IDLE: begin
                pipe_en = !mem_req;
                if (mem_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.bus_ready || abort) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // mem_req still belongs to the completing instruction here.
                pipe_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep the pipeline frozen for the whole time reset is asserted.
        if (!rst) begin
            pipe_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            load_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        valid_q <= 1'b1;
                        we_q    <= mem_we;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        mask_q  <= mem_mask;
                    end
                end
                REQ: begin
                    if (bus.bus_ready) begin
                        valid_q <= 1'b0;
                        if (!we_q) begin
                            load_q <= bus.bus_rdata;
                        end
                    end else if (abort) begin
                        valid_q <= 1'b0;
                        load_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_valid = valid_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_mask  = mask_q;
    assign load_data     = load_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_pipe_ctrl.sv
// tb_lsu_pipe_ctrl
//   Self-checking bench for lsu_pipe_ctrl: a cycle table for the basic
//   load/store sequences, hand-written corner sequences (back-to-back ops,
//   reset mid-request, timeout abort when LSU_TIMEOUT_EN is defined), and a
//   random instruction stream checked against a per-instruction cycle-cost
//   and ordered-handshake model.
module tb_lsu_pipe_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_mask;
    logic          pipe_en;
    logic [31:0]   load_data;
    logic          busy;
    logic          timeout_err;

    lsu_pipe_ctrl_if #(.DW(DW), .AW(AW)) bus_if ();

    lsu_pipe_ctrl #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mask    (mem_mask),
        .bus         (bus_if),
        .pipe_en     (pipe_en),
        .load_data   (load_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [31:0] exp_load;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        rdy;
        logic [31:0] rdata;
        logic        pe;
        logic        valid;
        logic        bsy;
        logic        bwe;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [3:0]  bmask;
        logic [31:0] ld;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mkv(
        input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] mask, input logic rdy, input logic [31:0] rdata,
        input logic pe, input logic valid, input logic bsy, input logic bwe,
        input logic [31:0] baddr, input logic [31:0] bwdata, input logic [3:0] bmask,
        input logic [31:0] ld);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.rdy = rdy; v.rdata = rdata; v.pe = pe; v.valid = valid; v.bsy = bsy;
        v.bwe = bwe; v.baddr = baddr; v.bwdata = bwdata; v.bmask = bmask; v.ld = ld;
        return v;
    endfunction

    typedef struct {
        bit          mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int unsigned w;
    } instr_t;

    instr_t prog[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic rdy, input logic [31:0] rdata);
        mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_mask = mask;
        bus_if.bus_ready = rdy;
        bus_if.bus_rdata = rdata;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("rst_valid", bus_if.bus_valid, 0);
        chk("rst_pipe_en", pipe_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        step();
        rst = 1'b1;
        exp_load = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs;
        int unsigned n_mem;
        int unsigned idx;
        int unsigned cyc_here;
        int unsigned vcnt;
        logic        pe;

        n_cmp = 0;
        n_bad = 0;
        exp_load = '0;
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);

        // Reset state while rst is held low.
        #12;
        chk("init_pipe_en", pipe_en, 0);
        chk("init_valid", bus_if.bus_valid, 0);
        chk("init_bus_fields", {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_mask}, 0);
        step();
        rst = 1'b1;

        // ---------------- table-driven sequence ----------------
        for (int i = 0; i < 5; i++)
            tbl[i] = mkv(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,
                         1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
        tbl[5]  = mkv(1, 0, 32'h100, 32'h0, 4'hF, 0, 32'h0,
                      0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
        tbl[6]  = mkv(1, 0, 32'h100, 32'h0, 4'hF, 1, 32'hDEADBEEF,
                      0, 1, 1, 0, 32'h100, 32'h0, 4'hF, 32'h0);
        tbl[7]  = mkv(1, 0, 32'h100, 32'h0, 4'hF, 0, 32'h0,
                      1, 0, 1, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF);
        tbl[8]  = mkv(1, 1, 32'h204, 32'h12345678, 4'h3, 1, 32'hFFFF0000,
                      0, 0, 0, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF);
        for (int i = 9; i < 12; i++)
            tbl[i] = mkv(1, 1, 32'h204, 32'h12345678, 4'h3, 0, 32'h0,
                         0, 1, 1, 1, 32'h204, 32'h12345678, 4'h3, 32'hDEADBEEF);
        tbl[12] = mkv(1, 1, 32'h204, 32'h12345678, 4'h3, 1, 32'hBAD0BAD0,
                      0, 1, 1, 1, 32'h204, 32'h12345678, 4'h3, 32'hDEADBEEF);
        tbl[13] = mkv(1, 1, 32'h204, 32'h12345678, 4'h3, 1, 32'h0,
                      1, 0, 1, 1, 32'h204, 32'h12345678, 4'h3, 32'hDEADBEEF);
        tbl[14] = mkv(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,
                      1, 0, 0, 1, 32'h204, 32'h12345678, 4'h3, 32'hDEADBEEF);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
                  tbl[i].rdy, tbl[i].rdata);
            @(negedge clk);
            chk($sformatf("row%0d_pipe_en", i), pipe_en, tbl[i].pe);
            chk($sformatf("row%0d_valid", i), bus_if.bus_valid, tbl[i].valid);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("row%0d_bus_we", i), bus_if.bus_we, tbl[i].bwe);
            chk($sformatf("row%0d_bus_addr", i), bus_if.bus_addr, tbl[i].baddr);
            chk($sformatf("row%0d_bus_wdata", i), bus_if.bus_wdata, tbl[i].bwdata);
            chk($sformatf("row%0d_bus_mask", i), bus_if.bus_mask, tbl[i].bmask);
            chk($sformatf("row%0d_load_data", i), load_data, tbl[i].ld);
            chk($sformatf("row%0d_timeout_err", i), timeout_err, 0);
            step();
        end

        // ---------------- back-to-back loads, mem_req held across DONE ----------------
        hs = 0;
        drive(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, 32'hA5A50001);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_if.bus_valid && bus_if.bus_ready) hs++;
            if (c == 2 || c == 5) begin
                chk($sformatf("b2b_done%0d_pipe_en", c), pipe_en, 1);
                chk($sformatf("b2b_done%0d_valid", c), bus_if.bus_valid, 0);
            end
            step();
        end
        mem_req = 1'b0;
        @(negedge clk);
        chk("b2b_handshakes", hs, 2);
        chk("b2b_load_data", load_data, 32'hA5A50001);
        chk("b2b_idle_pipe_en", pipe_en, 1);
        step();

        // ---------------- reset asserted mid-REQ ----------------
        drive(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("midrst_req_valid", bus_if.bus_valid, 1);
        #2;
        rst = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("midrst_valid_drop", bus_if.bus_valid, 0);
        chk("midrst_pipe_en", pipe_en, 0);
        chk("midrst_busy", busy, 0);
        #3;
        rst = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_valid", c), bus_if.bus_valid, 0);
            chk($sformatf("postrst%0d_busy", c), busy, 0);
            chk($sformatf("postrst%0d_pipe_en", c), pipe_en, 1);
            step();
        end
        mem_req = 1'b1;
        @(negedge clk);
        chk("reissue_idle_valid", bus_if.bus_valid, 0);
        step();
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h00000077;
        @(negedge clk);
        chk("reissue_valid", bus_if.bus_valid, 1);
        chk("reissue_addr", bus_if.bus_addr, 32'h400);
        step();
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        chk("reissue_done_pipe_en", pipe_en, 1);
        chk("reissue_load_data", load_data, 32'h77);
        step();
        mem_req = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // ---------------- timeout abort, bus_ready tied low ----------------
        drive(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        step();
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            chk($sformatf("to_req%0d_valid", c), bus_if.bus_valid, 1);
            chk($sformatf("to_req%0d_pipe_en", c), pipe_en, 0);
            chk($sformatf("to_req%0d_err", c), timeout_err, 0);
            step();
        end
        @(negedge clk);
        chk("to_done_pipe_en", pipe_en, 1);
        chk("to_done_valid", bus_if.bus_valid, 0);
        chk("to_done_load_data", load_data, 0);
        chk("to_done_err", timeout_err, 1);
        step();
        mem_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("to_sticky%0d", c), timeout_err, 1);
            step();
        end
`endif

        // ---------------- random instruction stream ----------------
        do_reset();
        n_mem = 0;
        for (int i = 0; i < 60; i++) begin
            instr_t it;
            it.mem   = ($urandom_range(0, 9) < 6);
            it.we    = $urandom_range(0, 1);
            it.addr  = {$urandom, 2'b00};
            it.wdata = $urandom;
            it.mask  = $urandom_range(0, 15);
            it.w     = $urandom_range(0, 3);
            if (it.mem) n_mem++;
            prog.push_back(it);
        end

        hs = 0;
        idx = 0;
        cyc_here = 0;
        vcnt = 0;
        while (idx < 60) begin
            drive(prog[idx].mem, prog[idx].we, prog[idx].addr, prog[idx].wdata,
                  prog[idx].mask, 1'b0, $urandom);
            // Responder completes the request on its (w+1)-th valid cycle;
            // ready is random (and must be ignored) when no request is up.
            if (bus_if.bus_valid) begin
                bus_if.bus_ready = (vcnt == prog[idx].w);
                vcnt++;
            end else begin
                bus_if.bus_ready = $urandom_range(0, 1);
            end
            @(negedge clk);
            cyc_here++;
            if (bus_if.bus_valid) begin
                chk($sformatf("rnd%0d_req_fields", idx),
                    {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_mask},
                    {prog[idx].we, prog[idx].addr, prog[idx].wdata, prog[idx].mask});
                if (bus_if.bus_ready) begin
                    hs++;
                    vcnt = 0;
                    if (!prog[idx].we) exp_load = bus_if.bus_rdata;
                end
            end
            pe = pipe_en;
            if (pe) begin
                chk($sformatf("rnd%0d_cycles", idx), cyc_here,
                    prog[idx].mem ? prog[idx].w + 3 : 1);
                if (prog[idx].mem)
                    chk($sformatf("rnd%0d_load_data", idx), load_data, exp_load);
                idx++;
                cyc_here = 0;
            end
            if (cyc_here > 40) begin
                chk($sformatf("rnd%0d_stall_bound", idx), cyc_here, 0);
                break;
            end
            step();
        end
        chk("rnd_handshakes", hs, n_mem);
        chk("rnd_timeout_err", timeout_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
